// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------
// fp_pkg: shared constants, FSM encoding and helpers for fp_add_arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package fp_pkg;

   localparam int FP_WIDTH = 32;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Leading-zero count of a 27-bit extended mantissa; 27 when all zero.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i <= 26; i++) begin
         if (v[i]) lzc27 = 5'(26 - i);
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/floating_unit.sv
// ---------------------------------------------------------------
// floating_unit: combinational IEEE-754 single add/sub, round-to-nearest-even
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module floating_unit
   import fp_pkg::*;
(
   input  logic [FP_WIDTH-1:0] a,
   input  logic [FP_WIDTH-1:0] b,
   input  logic                op,
   output logic [FP_WIDTH-1:0] result
);

   logic        sa, sb, sx, sy;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf;
   logic [9:0]  ex, ey, e_norm, e_fld;
   logic [23:0] mx, my;
   logic [7:0]  d;
   logic [26:0] ext_y, shifted, aligned, m;
   logic        lost, rnd_up;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [9:0]  sh;
   logic [24:0] r25;
   logic [22:0] frac;

   always_comb begin
      sa     = a[31];
      sb     = b[31] ^ (op != OP_ADD);
      ea     = a[30:23];
      eb     = b[30:23];
      fa     = a[22:0];
      fb     = b[22:0];
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);

      // x is the operand of larger magnitude; denormals use exponent 1.
      if (b[30:0] > a[30:0]) begin
         sx = sb; sy = sa;
         ex = {2'b00, (eb == 8'd0) ? 8'd1 : eb};
         ey = {2'b00, (ea == 8'd0) ? 8'd1 : ea};
         mx = {eb != 8'd0, fb};
         my = {ea != 8'd0, fa};
      end else begin
         sx = sa; sy = sb;
         ex = {2'b00, (ea == 8'd0) ? 8'd1 : ea};
         ey = {2'b00, (eb == 8'd0) ? 8'd1 : eb};
         mx = {ea != 8'd0, fa};
         my = {eb != 8'd0, fb};
      end

      d     = 8'(ex - ey);
      ext_y = {my, 3'b000};
      if (d >= 8'd27) begin
         shifted = 27'd0;
         lost    = |my;
      end else begin
         shifted = ext_y >> d;
         lost    = |(ext_y & ~({27{1'b1}} << d));
      end
      aligned = {shifted[26:1], shifted[0] | lost};

      if (sx == sy) sum = {1'b0, mx, 3'b000} + {1'b0, aligned};
      else          sum = {1'b0, mx, 3'b000} - {1'b0, aligned};

      lz = lzc27(sum[26:0]);
      sh = 10'd0;
      if (sum[27]) begin
         m      = {sum[27:2], sum[1] | sum[0]};
         e_norm = ex + 10'd1;
      end else begin
         sh     = ({5'd0, lz} > (ex - 10'd1)) ? (ex - 10'd1) : {5'd0, lz};
         m      = sum[26:0] << sh;
         e_norm = ex - sh;
      end
      e_fld  = m[26] ? e_norm : 10'd0;

      rnd_up = m[2] & (m[1] | m[0] | m[3]);
      r25    = {1'b0, m[26:3]} + {24'd0, rnd_up};
      if (r25[24]) begin
         e_fld = e_fld + 10'd1;
         frac  = r25[23:1];
      end else begin
         if ((e_fld == 10'd0) && r25[23]) e_fld = 10'd1;
         frac = r25[22:0];
      end

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) result = 32'h7FC0_0000;
      else if (a_inf)                                        result = {sa, 8'hFF, 23'd0};
      else if (b_inf)                                        result = {sb, 8'hFF, 23'd0};
      else if (sum == 28'd0)                                 result = {sx & sy, 31'd0};
      else if (e_fld >= 10'd255)                             result = {sx, 8'hFF, 23'd0};
      else                                                   result = {sx, e_fld[7:0], frac};
   end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting at ptr
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------
// fp_add_arbiter: NREQ requesters share one floating_unit via round-robin
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fp_add_arbiter
   import fp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2,
   parameter int IDW   = $clog2(NREQ),
   parameter int CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  busy,
   output logic [CNTW-1:0]       op_count
);

   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   out_id_q, out_id_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             sub_q, sub_d;
   logic             out_valid_q, out_valid_d;
   logic [CNTW-1:0]  op_count_q, op_count_d;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [WIDTH-1:0] fu_result;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // The adder only ever sees registered operands, never live request lines.
   floating_unit u_fu (
      .a      (a_q),
      .b      (b_q),
      .op     (sub_q),
      .result (fu_result)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_valid_d = out_valid_q;
      op_count_d  = op_count_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               a_d      = req_a[grant_idx*WIDTH +: WIDTH];
               b_d      = req_b[grant_idx*WIDTH +: WIDTH];
               sub_d    = req_sub[grant_idx];
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            out_data_d  = fu_result;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               op_count_d  = op_count_q + 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_valid_q <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_valid_q <= out_valid_d;
         op_count_q  <= op_count_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------
// tb_fp_add_arbiter: directed stimulus with a queue-based result scoreboard
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fp_add_arbiter;

   localparam int NREQ = 2;
   localparam int IDW  = 1;
   // Narrow counter so the wrap boundary is reached in a short run.
   localparam int CNTW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_a = '0;
   logic [NREQ*32-1:0]   req_b = '0;
   logic [NREQ-1:0]      req_sub = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [31:0]          out_data;
   logic [IDW-1:0]       out_id;
   logic                 busy;
   logic [CNTW-1:0]      op_count;

   typedef struct packed {
      logic [31:0]    data;
      logic [IDW-1:0] id;
   } exp_t;

   exp_t            sb_q[$];
   int              checks   = 0;
   int              failures = 0;
   logic [CNTW-1:0] exp_cnt  = '0;

   fp_add_arbiter #(
      .WIDTH (32),
      .NREQ  (NREQ),
      .IDW   (IDW),
      .CNTW  (CNTW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_grant(output logic [NREQ-1:0] g);
      g = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            g = req_ready;
            break;
         end
      end
      if (g == '0) begin
         checks++;
         failures++;
         $display("FAIL grant_timeout: got no req_ready expected a grant at %0t", $time);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!busy && sb_q.size() == 0) break;
      end
      check("drain_queue", sb_q.size(), 0);
   endtask

   task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp, input bit lat);
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] want;
      want = '0;
      want[id] = 1'b1;
      @(posedge clk); #1;
      req_a[id*32 +: 32] = a;
      req_b[id*32 +: 32] = b;
      req_sub[id]        = sub;
      req_valid[id]      = 1'b1;
      wait_grant(g);
      check("grant_onehot", 32'(g), 32'(want));
      if (g == want) sb_q.push_back('{data: exp, id: IDW'(id)});
      @(posedge clk); #1;
      // Scramble the request after acceptance; the in-flight op must not see it.
      req_valid[id]      = 1'b0;
      req_a[id*32 +: 32] = ~a;
      req_b[id*32 +: 32] = 32'h1234_5678;
      req_sub[id]        = ~sub;
      if (lat) begin
         @(negedge clk);
         check("lat_exec_valid", 32'(out_valid), 0);
         check("lat_exec_busy",  32'(busy), 1);
         check("lat_exec_ready", 32'(req_ready), 0);
         @(negedge clk);
         check("lat_resp_valid", 32'(out_valid), 1);
      end
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_cnt = '0;
         end else if (out_valid && out_ready) begin
            check("op_count", 32'(op_count), 32'(exp_cnt));
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got data %h id %0d expected none", out_data, out_id);
            end else begin
               e = sb_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_id", 32'(out_id), 32'(e.id));
            end
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] tv_a [7] = '{32'h3F80_0000, 32'h4040_0000, 32'h7F80_0000, 32'h0000_0001,
                             32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F80_0000};
   logic [31:0] tv_b [7] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001,
                             32'h7F7F_FFFF, 32'hBF80_0000, 32'h7F80_0000};
   logic        tv_s [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] tv_r [7] = '{32'h4000_0000, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0002,
                             32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};

   initial begin
      logic [NREQ-1:0] g;
      logic [CNTW-1:0] cnt_stall;

      // Reset state, with a request pending that must not be granted
      req_valid = 2'b01;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy",      32'(busy), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_op_count",  32'(op_count), 0);
      check("rst_out_data",  out_data, 0);
      check("rst_out_id",    32'(out_id), 0);
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;

      // Single add with latency check, RNE tie stays even
      do_op(0, 32'h3E8C_0001, 32'h3F18_0000, 1'b0, 32'h3F5E_0000, 1'b1);
      wait_idle();

      // Requester 1 alone: exact cancellation both ways gives +0
      do_op(1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
      do_op(1, 32'hBFFF_FFFF, 32'h3FFF_FFFF, 1'b0, 32'h0000_0000, 1'b0);
      wait_idle();

      // Both valid continuously: strict rotation 0,1,0,1
      @(posedge clk); #1;
      req_a     = {32'h3FFF_FFFF, 32'h3FFF_FFFF};
      req_b     = {32'h3FFF_FFFF, 32'h3FFF_FFFF};
      req_sub   = 2'b00;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         check("rotation", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
         if (g != '0) sb_q.push_back('{data: 32'h407F_FFFF, id: IDW'(k % 2)});
         @(posedge clk);
      end
      #1 req_valid = 2'b00;
      wait_idle();

      // Back-pressure: result held, no grants while stalled
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      @(posedge clk); #1;
      req_a[32 +: 32] = 32'h4000_0000;
      req_b[32 +: 32] = 32'h3F80_0000;
      req_sub[1]      = 1'b1;
      req_valid[1]    = 1'b1;
      cnt_stall       = exp_cnt;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("stall_valid",    32'(out_valid), 1);
         check("stall_data",     out_data, 32'h4000_0000);
         check("stall_ready",    32'(req_ready), 0);
         check("stall_op_count", 32'(op_count), 32'(cnt_stall));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_grant(g);
      check("after_stall_grant", 32'(g), 32'd2);
      check("after_stall_count", 32'(op_count), 32'(CNTW'(cnt_stall + 1'b1)));
      if (g != '0) sb_q.push_back('{data: 32'h3F80_0000, id: 1'b1});
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_idle();

      // Reset while the op is in EXEC: discarded, outputs drop at once
      @(posedge clk); #1;
      req_a[0 +: 32] = 32'h3F80_0000;
      req_b[0 +: 32] = 32'h3F80_0000;
      req_sub[0]     = 1'b0;
      req_valid[0]   = 1'b1;
      wait_grant(g);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_busy",  32'(busy), 0);
      check("mid_rst_count", 32'(op_count), 0);
      @(posedge clk); #3;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 32'(busy), 0);
      do_op(1, 32'hBFFF_FFFF, 32'hBFFF_FFFF, 1'b0, 32'hC07F_FFFF, 1'b1);
      wait_idle();

      // Special values plus counter wrap (17 completions since reset)
      for (int i = 0; i < 16; i++) begin
         do_op(i % 2, tv_a[i % 7], tv_b[i % 7], tv_s[i % 7], tv_r[i % 7], 1'b0);
      end
      wait_idle();
      check("wrap_op_count", 32'(op_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
